sevenseg_scan_driver: RTL

//   Parametrised, time-multiplexed driver for an N-digit 7-segment display.

---
 rtl/sevenseg_scan_driver.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: double-buffered digit codes, per-slot
// anti-ghost blanking, leading-zero suppression, hex/BCD decode and pin polarity.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int HEX_EN       = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } slot_state_t;

  localparam slot_state_t RESET_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  logic [4*NUM_DIGITS-1:0] pend_digits;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] act_digits;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             boundary;

  slot_state_t state;
  slot_state_t state_next;

  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_q;
  logic [6:0]            seg_next;
  logic                  dp_q;
  logic                  dp_next;
  logic                  frame_done_q;

  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] upper_zero;

  function automatic slot_state_t slot_of(input logic [CNT_W-1:0] c);
    slot_of = ((BLANK_CYCLES > 0) && (c < BLANK_LIM)) ? S_BLANK : S_DRIVE;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h73;
      4'hA:    s = (HEX_EN != 0) ? 7'h77 : 7'h00;
      4'hB:    s = (HEX_EN != 0) ? 7'h1F : 7'h00;
      4'hC:    s = (HEX_EN != 0) ? 7'h4E : 7'h00;
      4'hD:    s = (HEX_EN != 0) ? 7'h3D : 7'h00;
      4'hE:    s = (HEX_EN != 0) ? 7'h4F : 7'h00;
      default: s = (HEX_EN != 0) ? 7'h47 : 7'h00;
    endcase
    decode = s;
  endfunction

  // Slot counter and digit index; a boundary is the slot end of the last digit.
  always_comb begin
    cnt_next = cnt;
    idx_next = idx;
    boundary = 1'b0;
    if (!enable) begin
      cnt_next = '0;
      idx_next = '0;
    end else if (cnt == LAST_CNT) begin
      cnt_next = '0;
      if (idx == LAST_IDX) begin
        idx_next = '0;
        boundary = 1'b1;
      end else begin
        idx_next = idx + IDX_W'(1);
      end
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // State always tracks the slot phase of the next count, so a restart from
  // disabled lands in the correct phase even when there is no blank phase.
  always_comb begin
    state_next = slot_of(cnt_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      state <= RESET_STATE;
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      state <= state_next;
    end
  end

  // load is a single-cycle strobe with no back-pressure: every edge with load=1
  // overwrites the pending buffer; the display only sees it at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
      end
      if (!enable || boundary) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
      end
    end
  end

  // upper_zero[i]: digit i and every more significant digit are zero.
  always_comb begin
    logic zero_run;
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (act_digits[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    suppress = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code = act_digits[4*i +: 4];
        cur_dp   = act_dp[i];
        suppress = lz_en && (i > 0) && upper_zero[i];
      end
    end
  end

  always_comb begin
    an_next  = '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (enable && (state == S_DRIVE)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_next[i] = (idx == IDX_W'(i));
      end
      seg_next = suppress ? 7'h00 : decode(cur_code);
      dp_next  = cur_dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q         <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_next;
      seg_q        <= seg_next;
      dp_q         <= dp_next;
      frame_done_q <= boundary;
    end
  end

  assign an         = (ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign seg        = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp         = (ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign frame_done = frame_done_q;

endmodule
